mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single shared memory port of the multicycle datapath. Two requesters compete for the port: instruction fetch from the main control FSM, and the data load/store path. The block replaces hand-coded memory wait states with a req/ack handshake. It drives the memory address, write data and write strobe, counts the fixed read latency, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_t     : FSM state encoding (also exported on stateout for debug)
//   grant_t     : requester identity (fetch or data path)
//   pick_winner : round-robin choice between the two requesters
package mem_arb_pkg;

  localparam int unsigned MemLatDefault = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } state_t;

  typedef enum logic {
    GntIf = 1'b0,
    GntD  = 1'b1
  } grant_t;

  // A lone requester wins; on a tie the one not served last wins.
  function automatic grant_t pick_winner(input logic   if_req,
                                         input logic   d_req,
                                         input grant_t last);
    if (if_req && d_req) begin
      return (last == GntIf) ? GntD : GntIf;
    end else if (d_req) begin
      return GntD;
    end
    return GntIf;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single shared memory port of the multicycle datapath.
// Two requesters (instruction fetch, data load/store) use a req/ack handshake; the
// block latches the winner's request, drives the memory port, counts the fixed read
// latency and returns read data with a one-cycle ack.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   if_req/if_addr          : fetch request (read only)
//   if_ack/if_rdata         : fetch completion pulse, fetched word
//   d_req/d_we/d_addr/d_wdata : data request (d_we=1 store, 0 load)
//   d_ack/d_rdata           : data completion pulse, loaded word
//   mem_addr/mem_wdata/mem_wr : memory port drive; mem_rdata : memory read data
//   busy, stateout          : not-idle flag and raw state encoding for debug
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = MemLatDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        stateout
);

  // A zero-width counter is not legal, so MEM_LAT=1 keeps a dummy bit.
  localparam int unsigned   CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = (MEM_LAT > 1) ? CntW'(MEM_LAT - 2) : '0;

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  grant_t              win_q, win_d;
  grant_t              last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                latch;
  grant_t              latch_sel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    mem_wr     = 1'b0;
    if_rdata   = if_rdata_q;
    d_rdata    = d_rdata_q;
    latch      = 1'b0;
    latch_sel  = GntIf;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          latch     = 1'b1;
          latch_sel = pick_winner(if_req, d_req, last_q);
        end
      end
      StIssue: begin
        mem_wr = we_q;
        if (we_q || (MEM_LAT == 1)) begin
          state_d = StAck;
        end else begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAck: begin
        last_d = win_q;
        if (win_q == GntIf) begin
          if_ack = 1'b1;
          if (!we_q) begin
            if_rdata   = mem_rdata;
            if_rdata_d = mem_rdata;
          end
        end else begin
          d_ack = 1'b1;
          if (!we_q) begin
            d_rdata   = mem_rdata;
            d_rdata_d = mem_rdata;
          end
        end
        // The acked requester still holds req high this cycle, so only the
        // other one may chain straight into a new ISSUE.
        if ((win_q == GntIf) ? d_req : if_req) begin
          latch     = 1'b1;
          latch_sel = (win_q == GntIf) ? GntD : GntIf;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      state_d = StIssue;
      win_d   = latch_sel;
      if (latch_sel == GntIf) begin
        addr_d  = if_addr;
        we_d    = 1'b0;
        wdata_d = '0;
      end else begin
        addr_d  = d_addr;
        we_d    = d_we;
        wdata_d = d_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      win_q      <= GntIf;
      last_q     <= GntD;  // fetch wins the first tie
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign stateout  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_wr, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  stateout;

  // Latency-variant instances, fetch only.
  logic        req_l1, req_l4;
  logic        ack_l1, ack_l4, dack_l1, dack_l4, wr_l1, wr_l4, busy_l1, busy_l4;
  logic [31:0] rd_l1, rd_l4, drd_l1, drd_l4, ma_l1, ma_l4, mw_l1, mw_l4;
  logic [1:0]  st_l1, st_l4;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_count = 0;
  int          last_ack_cyc = 0;
  int          wr_count = 0;
  exp_t        q[$];
  logic [31:0] hold_if, hold_d;
  logic [31:0] exp_wr_addr, exp_wr_data;
  logic [31:0] apipe0, apipe1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h2001_0001;
  endfunction

  // Memory model: data appears two cycles after the address is presented.
  always @(posedge clock) begin
    apipe0 <= mem_addr;
    apipe1 <= apipe0;
  end
  assign mem_rdata = mem_fn(apipe1);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .stateout(stateout)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_l1 (
    .clock(clock), .reset(reset),
    .if_req(req_l1), .if_addr(if_addr), .if_ack(ack_l1), .if_rdata(rd_l1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(dack_l1), .d_rdata(drd_l1),
    .mem_addr(ma_l1), .mem_wdata(mw_l1), .mem_wr(wr_l1), .mem_rdata(mem_fn(ma_l1)),
    .busy(busy_l1), .stateout(st_l1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_l4 (
    .clock(clock), .reset(reset),
    .if_req(req_l4), .if_addr(if_addr), .if_ack(ack_l4), .if_rdata(rd_l4),
    .d_req(1'b0), .d_we(1'b0), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(dack_l4), .d_rdata(drd_l4),
    .mem_addr(ma_l4), .mem_wdata(mw_l4), .mem_wr(wr_l4), .mem_rdata(mem_fn(ma_l4)),
    .busy(busy_l4), .stateout(st_l4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected completion per ack of the main instance.
  always @(negedge clock) begin
    exp_t it;
    if (reset) begin
      hold_if = '0;
      hold_d  = '0;
    end else begin
      if (if_ack || d_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {62'd0, if_ack, d_ack}, 64'd0);
        end else begin
          it = q.pop_front();
          chk("ack_port", {62'd0, if_ack, d_ack}, it.is_d ? 64'd1 : 64'd2);
          if (it.is_d && it.we) begin
            chk("store_d_rdata", d_rdata, hold_d);
          end else if (it.is_d) begin
            chk("load_d_rdata", d_rdata, it.data);
            hold_d = it.data;
          end else begin
            chk("fetch_rdata", if_rdata, it.data);
            hold_if = it.data;
          end
        end
        ack_count++;
        last_ack_cyc = cyc;
      end
      if (mem_wr) begin
        wr_count++;
        chk("wr_addr", mem_addr, exp_wr_addr);
        chk("wr_data", mem_wdata, exp_wr_data);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acks(input int target, input string tag);
    int n = 0;
    while (ack_count < target && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_ack_seen"}, (ack_count >= target) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    automatic int t0 = 0;
    automatic int w0 = 0;
    automatic int a1 = 0;
    automatic int ack1 = 0;
    automatic int ack4 = 0;
    automatic int waits4 = 0;
    automatic bit saw_wait1 = 0;
    automatic bit drop1 = 0;
    automatic bit drop4 = 0;
    automatic logic [31:0] r1 = '0;
    automatic logic [31:0] r4 = '0;

    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; req_l1 = 0; req_l4 = 0;
    if_addr = '0; d_addr = '0; d_wdata = 32'h1234_5678;
    exp_wr_addr = '0; exp_wr_data = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_ctl", {60'd0, mem_wr, if_ack, d_ack, busy}, 0);
    chk("rst_state", stateout, 0);

    // Single fetch
    step();
    if_addr = 32'h4; if_req = 1; t0 = cyc; w0 = wr_count;
    q.push_back('{is_d: 1'b0, we: 1'b0, data: 32'h2001_0005});
    wait_acks(1, "fetch");
    if_req = 0;
    chk("fetch_latency", last_ack_cyc - t0, 3);
    chk("fetch_no_wr", wr_count - w0, 0);
    @(negedge clock);
    chk("fetch_hold", if_rdata, 32'h2001_0005);
    chk("fetch_idle", {62'd0, stateout}, 0);
    chk("fetch_ack_pulse", if_ack, 0);

    // Store
    step();
    d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_we = 1; d_req = 1;
    exp_wr_addr = 32'h100; exp_wr_data = 32'hDEAD_BEEF;
    t0 = cyc; w0 = wr_count;
    q.push_back('{is_d: 1'b1, we: 1'b1, data: 32'h0});
    wait_acks(2, "store");
    d_req = 0; d_we = 0;
    chk("store_latency", last_ack_cyc - t0, 2);
    chk("store_one_wr", wr_count - w0, 1);

    // Contention: IF, D, IF, D with no IDLE between alternating grants
    reset = 1; step(); step(); reset = 0;
    if_addr = 32'h10; d_addr = 32'h20; if_req = 1; d_req = 1; t0 = cyc;
    q.push_back('{is_d: 1'b0, we: 1'b0, data: mem_fn(32'h10)});
    q.push_back('{is_d: 1'b1, we: 1'b0, data: mem_fn(32'h20)});
    q.push_back('{is_d: 1'b0, we: 1'b0, data: mem_fn(32'h10)});
    q.push_back('{is_d: 1'b1, we: 1'b0, data: mem_fn(32'h20)});
    w0 = ack_count;
    wait_acks(w0 + 1, "cont1");
    chk("cont1_cyc", last_ack_cyc - t0, 3);
    wait_acks(w0 + 2, "cont2");
    chk("cont2_cyc", last_ack_cyc - t0, 6);
    wait_acks(w0 + 3, "cont3");
    chk("cont3_cyc", last_ack_cyc - t0, 9);
    if_req = 0;
    wait_acks(w0 + 4, "cont4");
    chk("cont4_cyc", last_ack_cyc - t0, 12);
    d_req = 0;
    @(negedge clock);
    chk("cont_idle", {62'd0, stateout}, 0);

    // Reset during WAIT of a fetch
    step();
    if_addr = 32'h40; if_req = 1; w0 = ack_count;
    step();
    step();
    reset = 1; if_req = 0;
    @(negedge clock);
    chk("pre_rst_wait", {62'd0, stateout}, 2);
    step();
    @(negedge clock);
    chk("midrst_state", {62'd0, stateout}, 0);
    chk("midrst_ctl", {60'd0, mem_wr, if_ack, d_ack, busy}, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_rdata", {if_rdata, d_rdata}, 0);
    chk("midrst_no_ack", ack_count - w0, 0);
    step();
    reset = 0;
    if_addr = 32'h44; d_addr = 32'h48; if_req = 1; d_req = 1; t0 = cyc;
    q.push_back('{is_d: 1'b0, we: 1'b0, data: mem_fn(32'h44)});
    q.push_back('{is_d: 1'b1, we: 1'b0, data: mem_fn(32'h48)});
    wait_acks(w0 + 1, "tie1");
    if_req = 0;
    chk("tie1_cyc", last_ack_cyc - t0, 3);
    wait_acks(w0 + 2, "tie2");
    d_req = 0;

    // Load after load: same requester goes back through IDLE
    step();
    d_addr = 32'h80; d_req = 1; w0 = ack_count;
    q.push_back('{is_d: 1'b1, we: 1'b0, data: mem_fn(32'h80)});
    wait_acks(w0 + 1, "ld1");
    a1 = last_ack_cyc;
    d_addr = 32'h84;
    q.push_back('{is_d: 1'b1, we: 1'b0, data: mem_fn(32'h84)});
    @(negedge clock);
    chk("ld_via_idle", {62'd0, stateout}, 0);
    chk("ld_hold", d_rdata, mem_fn(32'h80));
    wait_acks(w0 + 2, "ld2");
    d_req = 0;
    chk("ld2_cyc", last_ack_cyc - a1, 4);

    // Latency variants MEM_LAT=1 and MEM_LAT=4
    step();
    if_addr = 32'h200; req_l1 = 1; req_l4 = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (drop1) req_l1 = 0;
      if (drop4) req_l4 = 0;
      @(negedge clock);
      if (ack_l1 && ack1 == 0) begin ack1 = c; drop1 = 1; r1 = rd_l1; end
      if (ack_l4 && ack4 == 0) begin ack4 = c; drop4 = 1; r4 = rd_l4; end
      if (st_l1 == 2'd2) saw_wait1 = 1;
      if (st_l4 == 2'd2) waits4++;
    end
    req_l1 = 0; req_l4 = 0;
    chk("lat1_ack_cyc", ack1, 2);
    chk("lat4_ack_cyc", ack4, 5);
    chk("lat1_no_wait", {63'd0, saw_wait1}, 0);
    chk("lat4_waits", waits4, 3);
    chk("lat1_rdata", r1, mem_fn(32'h200));
    chk("lat4_rdata", r4, mem_fn(32'h200));

    step();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
